// File: rtl/pipe_event_monitor.sv
// Run-cycle and per-event statistics counters for the CPU pipeline, with a
// programmable cycle budget and a one-cycle-latency indexed read port.
module pipe_event_monitor #(
    parameter int NUM_EVT    = 4,
    parameter int CNT_W      = 32,
    parameter int IDX_W      = 4,
    parameter int MAX_CYCLES = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               rd_req_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic               rd_valid_o,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic               rd_err_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               running_o,
    output logic               done_o
);

    // Counter NUM_EVT is the run-cycle counter; 0..NUM_EVT-1 are event counters.
    localparam int NCNT = NUM_EVT + 1;
    localparam int CYC  = NUM_EVT;

    // A budget that does not fit in CNT_W bits can never be reached: treat as unlimited.
    localparam longint unsigned MAX_U   = 64'(MAX_CYCLES);
    localparam longint unsigned CNT_TOP = (CNT_W >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                        : ((64'd1 << CNT_W) - 64'd1);
    localparam bit              LIMITED = (MAX_U != 64'd0) && (MAX_U <= CNT_TOP);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_U);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             running_q;
    logic             done_q;

    logic [CNT_W-1:0] cnt_q [NCNT];
    logic [CNT_W-1:0] cnt_d [NCNT];
    logic [NCNT-1:0]  ovf_q;
    logic [NCNT-1:0]  ovf_d;
    logic [NCNT-1:0]  inc;
    logic [NCNT-1:0]  bump;
    logic [NCNT-1:0]  sat;
    logic             count_en;
    logic             hit_max;

    logic             rd_valid_q;
    logic             rd_err_q;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_sel;
    logic             rd_oob;

    // Counting happens on the IDLE->RUN edge as well as every RUN edge with start held.
    assign count_en = start_i && (state_q != ST_DONE);
    assign inc      = {1'b1, evt_i};

    generate
        for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
            assign sat[gi]   = &cnt_q[gi];
            assign bump[gi]  = count_en & inc[gi];
            assign cnt_d[gi] = clear_i                  ? '0 :
                               (bump[gi] && !sat[gi])   ? cnt_q[gi] + CNT_W'(1) :
                                                          cnt_q[gi];
            assign ovf_d[gi] = !clear_i && (ovf_q[gi] || (bump[gi] && sat[gi]));
        end
    endgenerate

    assign hit_max = LIMITED && count_en && !clear_i && (cnt_d[CYC] == MAX_C);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q   <= hit_max ? ST_DONE : ST_RUN;
                        running_q <= !hit_max;
                        done_q    <= hit_max;
                    end
                end
                ST_RUN: begin
                    if (!start_i) begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (hit_max) begin
                        state_q   <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    // Read mux samples the pre-update counter values, so a read never sees this edge's events.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NCNT; k++) begin
            if (rd_idx_i == IDX_W'(k)) begin
                rd_sel = cnt_q[k];
            end
        end
    end

    assign rd_oob = rd_idx_i > IDX_W'(NUM_EVT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_oob ? '0 : rd_sel;
                rd_err_q  <= rd_oob;
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_err_o   = rd_err_q;
    assign ovf_o      = ovf_q;
    assign running_o  = running_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_pipe_event_monitor.sv
// Directed bench for pipe_event_monitor: default instance plus a narrow
// (CNT_W=4, unlimited) instance for saturation behaviour.
module tb_pipe_event_monitor;

    logic        clk = 1'b0;
    logic        rst;
    int          checks   = 0;
    int          failures = 0;

    logic        start, clear, rd_req;
    logic [3:0]  evt, rd_idx;
    logic        rd_valid, rd_err, running, done;
    logic [31:0] rd_data;
    logic [4:0]  ovf;

    logic        s_start, s_clear, s_rd_req;
    logic [3:0]  s_evt, s_rd_idx;
    logic        s_rd_valid, s_rd_err, s_running, s_done;
    logic [3:0]  s_rd_data;
    logic [4:0]  s_ovf;

    always #5 clk = ~clk;

    pipe_event_monitor #(.NUM_EVT(4), .CNT_W(32), .IDX_W(4), .MAX_CYCLES(30)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .evt_i(evt),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .rd_err_o(rd_err), .ovf_o(ovf), .running_o(running), .done_o(done)
    );

    pipe_event_monitor #(.NUM_EVT(4), .CNT_W(4), .IDX_W(4), .MAX_CYCLES(0)) dut_sat (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .clear_i(s_clear), .evt_i(s_evt),
        .rd_req_i(s_rd_req), .rd_idx_i(s_rd_idx), .rd_valid_o(s_rd_valid), .rd_data_o(s_rd_data),
        .rd_err_o(s_rd_err), .ovf_o(s_ovf), .running_o(s_running), .done_o(s_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] idx);
        rd_req = 1'b1;
        rd_idx = idx;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic s_rd(input logic [3:0] idx);
        s_rd_req = 1'b1;
        s_rd_idx = idx;
        tick();
        s_rd_req = 1'b0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (ovf !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 32'd0 || rd_err !== 1'b0 ||
            running !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: ovf=%b valid=%b data=%0d err=%b run=%b done=%b required all 0",
                     ovf, rd_valid, rd_data, rd_err, running, done);
        end
        #11 rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic;
        logic [3:0]  idx_tab [5] = '{4'd4, 4'd0, 4'd1, 4'd2, 4'd3};
        logic [31:0] exp_tab [5] = '{32'd30, 32'd3, 32'd1, 32'd0, 32'd0};
        start = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            evt = 4'd0;
            if (n >= 3 && n <= 5) evt[0] = 1'b1;
            if (n == 10) evt[1] = 1'b1;
            tick();
            if (n == 29) begin
                checks++;
                if (running !== 1'b1 || done !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_edge29: run=%b done=%b required run=1 done=0", running, done);
                end
            end
            if (n == 30) begin
                checks++;
                if (running !== 1'b0 || done !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_edge30: run=%b done=%b required run=0 done=1", running, done);
                end
            end
        end
        evt = 4'b1111;
        tick();
        start = 1'b0;
        tick();
        evt = 4'd0;
        checks++;
        if (done !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_terminal: run=%b done=%b required run=0 done=1", running, done);
        end
        for (int i = 0; i < 5; i++) begin
            rd(idx_tab[i]);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_tab[i] || rd_err !== 1'b0) begin
                failures++;
                $display("FAIL basic_read idx=%0d: valid=%b data=%0d err=%b required 1/%0d/0",
                         idx_tab[i], rd_valid, rd_data, rd_err, exp_tab[i]);
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_pause_resume;
        do_clear();
        start = 1'b1;
        evt   = 4'b0100;
        for (int n = 0; n < 10; n++) tick();
        start = 1'b0;
        tick();
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL pause_running: run=%b required 0", running);
        end
        rd(4'd4);
        checks++;
        if (rd_data !== 32'd10) begin
            failures++;
            $display("FAIL pause_cycles: data=%0d required 10", rd_data);
        end
        rd(4'd2);
        checks++;
        if (rd_data !== 32'd10) begin
            failures++;
            $display("FAIL pause_evt2: data=%0d required 10", rd_data);
        end
        tick();
        tick();
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 19) begin
                checks++;
                if (done !== 1'b0) begin
                    failures++;
                    $display("FAIL resume_edge19: done=%b required 0", done);
                end
            end
            if (n == 20) begin
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL resume_edge20: done=%b required 1", done);
                end
            end
        end
        evt = 4'd0;
        rd(4'd2);
        checks++;
        if (rd_data !== 32'd30) begin
            failures++;
            $display("FAIL resume_evt2: data=%0d required 30", rd_data);
        end
        rd(4'd4);
        checks++;
        if (rd_data !== 32'd30) begin
            failures++;
            $display("FAIL resume_cycles: data=%0d required 30", rd_data);
        end
        start = 1'b0;
        $display("test_pause_resume done");
    endtask

    task automatic test_saturation;
        s_start = 1'b1;
        s_evt   = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 15) begin
                checks++;
                if (s_ovf !== 5'b00000) begin
                    failures++;
                    $display("FAIL sat_ovf_edge15: ovf=%b required 00000", s_ovf);
                end
            end
            if (n == 16) begin
                checks++;
                if (s_ovf !== 5'b10001) begin
                    failures++;
                    $display("FAIL sat_ovf_edge16: ovf=%b required 10001", s_ovf);
                end
            end
        end
        checks++;
        if (s_running !== 1'b1 || s_done !== 1'b0 || s_ovf !== 5'b10001) begin
            failures++;
            $display("FAIL sat_unlimited: run=%b done=%b ovf=%b required 1/0/10001", s_running, s_done, s_ovf);
        end
        s_start = 1'b0;
        s_evt   = 4'd0;
        tick();
        s_rd(4'd0);
        checks++;
        if (s_rd_data !== 4'd15 || s_rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL sat_read_evt0: data=%0d valid=%b required 15/1", s_rd_data, s_rd_valid);
        end
        s_rd(4'd4);
        checks++;
        if (s_rd_data !== 4'd15) begin
            failures++;
            $display("FAIL sat_read_cycles: data=%0d required 15", s_rd_data);
        end
        s_clear = 1'b1;
        tick();
        s_clear = 1'b0;
        checks++;
        if (s_ovf !== 5'd0) begin
            failures++;
            $display("FAIL sat_clear_ovf: ovf=%b required 00000", s_ovf);
        end
        $display("test_saturation done");
    endtask

    task automatic test_clear_priority;
        do_clear();
        start = 1'b1;
        evt   = 4'd0;
        for (int n = 0; n < 29; n++) tick();
        clear  = 1'b1;
        evt    = 4'b1111;
        rd_req = 1'b1;
        rd_idx = 4'd4;
        tick();
        clear = 1'b0;
        evt   = 4'd0;
        checks++;
        if (done !== 1'b0 || running !== 1'b0 || ovf !== 5'd0) begin
            failures++;
            $display("FAIL clr_state: done=%b run=%b ovf=%b required 0/0/00000", done, running, ovf);
        end
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd29) begin
            failures++;
            $display("FAIL clr_read_preclear: valid=%b data=%0d required 1/29", rd_valid, rd_data);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_data !== 32'd0 || running !== 1'b1) begin
            failures++;
            $display("FAIL clr_reenter: data=%0d run=%b required 0/1", rd_data, running);
        end
        start = 1'b0;
        rd(4'd0);
        checks++;
        if (rd_data !== 32'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL clr_evt0: data=%0d run=%b required 0/0", rd_data, running);
        end
        rd(4'd4);
        checks++;
        if (rd_data !== 32'd1) begin
            failures++;
            $display("FAIL clr_cycles_restart: data=%0d required 1", rd_data);
        end
        $display("test_clear_priority done");
    endtask

    task automatic test_read_edges;
        do_clear();
        start = 1'b1;
        evt   = 4'b0001;
        for (int n = 0; n < 5; n++) tick();
        rd_req = 1'b1;
        rd_idx = 4'd4;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd5 || rd_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_same_cycle_idx4: valid=%b data=%0d err=%b required 1/5/0", rd_valid, rd_data, rd_err);
        end
        rd_idx = 4'd0;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd6) begin
            failures++;
            $display("FAIL rd_same_cycle_idx0: valid=%b data=%0d required 1/6", rd_valid, rd_data);
        end
        rd_req = 1'b0;
        start  = 1'b0;
        evt    = 4'd0;
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 32'd6 || rd_err !== 1'b0) begin
            failures++;
            $display("FAIL rd_hold: valid=%b data=%0d err=%b required 0/6/0", rd_valid, rd_data, rd_err);
        end
        rd_req = 1'b1;
        rd_idx = 4'd5;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0 || rd_err !== 1'b1) begin
            failures++;
            $display("FAIL rd_oob5: valid=%b data=%0d err=%b required 1/0/1", rd_valid, rd_data, rd_err);
        end
        rd_idx = 4'd15;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd0 || rd_err !== 1'b1) begin
            failures++;
            $display("FAIL rd_oob15: valid=%b data=%0d err=%b required 1/0/1", rd_valid, rd_data, rd_err);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_err !== 1'b1) begin
            failures++;
            $display("FAIL rd_err_hold: valid=%b err=%b required 0/1", rd_valid, rd_err);
        end
        $display("test_read_edges done");
    endtask

    task automatic test_async_reset;
        do_clear();
        start = 1'b1;
        evt   = 4'b0010;
        for (int n = 0; n < 11; n++) tick();
        rd_req = 1'b1;
        rd_idx = 4'd4;
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 32'd11) begin
            failures++;
            $display("FAIL arst_preread: valid=%b data=%0d required 1/11", rd_valid, rd_data);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (running !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'd0 || ovf !== 5'd0) begin
            failures++;
            $display("FAIL arst_immediate: run=%b done=%b valid=%b data=%0d ovf=%b required all 0",
                     running, done, rd_valid, rd_data, ovf);
        end
        evt = 4'd0;
        tick();
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL arst_held: run=%b required 0", running);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL arst_rerun: run=%b required 1", running);
        end
        start = 1'b0;
        rd(4'd4);
        checks++;
        if (rd_data !== 32'd1) begin
            failures++;
            $display("FAIL arst_cycle_restart: data=%0d required 1", rd_data);
        end
        rd(4'd1);
        checks++;
        if (rd_data !== 32'd0) begin
            failures++;
            $display("FAIL arst_evt1_discarded: data=%0d required 0", rd_data);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; clear = 1'b0; evt = 4'd0; rd_req = 1'b0; rd_idx = 4'd0;
        s_start = 1'b0; s_clear = 1'b0; s_evt = 4'd0; s_rd_req = 1'b0; s_rd_idx = 4'd0;
        test_reset();
        test_basic();
        test_pause_resume();
        test_saturation();
        test_clear_priority();
        test_read_edges();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
